// File: rtl/mac_pkg.sv
// Shared MAC/drain definitions: drain FSM states, drain FIFO depth, result width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mac_pkg;

    localparam int DATA_WIDTH_INIT_MATRIX = 32;
    localparam int K                      = 4;

    // Result word width shared by the MAC accumulator and the drain: product plus K-way growth
    function automatic int result_width(input int init_width, input int k_dim);
        return init_width * 2 + $clog2(k_dim);
    endfunction

    localparam int RESULT_WIDTH     = result_width(DATA_WIDTH_INIT_MATRIX, K);
    localparam int DRAIN_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/mat_c_drain_if.sv
// Output element stream of the C drain: valid/ready with element value and (row, col, last) tags.
// Latency: n/a (wires only).
// Backpressure: master holds all out_* stable while out_valid && !out_ready.
interface mat_c_drain_if #(
    parameter int OUT_WIDTH = 32,
    parameter int ROW_W     = 2,
    parameter int COL_W     = 2
);
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [ROW_W-1:0]     out_row;
    logic [COL_W-1:0]     out_col;
    logic                 out_last;

    modport master (
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/mat_c_fifo.sv
// Small synchronous FIFO holding drained elements {data, row, col, last}; head is always visible.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the producer's credit rule keeps it from overflowing.
module mat_c_fifo
    import mac_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = DRAIN_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears storage so the head reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mat_c_drain.sv
// Reads result matrix C from SRAM in row-major order and streams one element per accepted beat.
// Latency: start at t -> first read t+1 -> first out_valid t+3; done the cycle after the last beat.
// Backpressure: reads are credit-limited to FIFO space (count + inflight < 4); out_* hold while stalled.
// Optional MAT_C_DRAIN_SAT_EN: saturate elements to OUT_WIDTH instead of truncating.
module mat_c_drain
    import mac_pkg::*;
#(
    parameter  int M                        = 4,
    parameter  int N                        = 4,
    parameter  int DATA_WIDTH_RESULT_MATRIX = RESULT_WIDTH,
    parameter  int OUT_WIDTH                = 32,
    localparam int ROW_W                    = $clog2(M),
    localparam int COL_W                    = $clog2(N)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                matrix_c_re,
    output logic [ROW_W-1:0]                    row_addr_c,
    output logic [COL_W-1:0]                    col_addr_c,
    input  logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
    mat_c_drain_if.master                       out_if
);

    localparam int DW    = DATA_WIDTH_RESULT_MATRIX;
    localparam int ENT_W = OUT_WIDTH + ROW_W + COL_W + 1;
    localparam int CNT_W = $clog2(DRAIN_FIFO_DEPTH + 1);

    drain_state_t         state;
    drain_state_t         state_nxt;
    logic [ROW_W-1:0]     row_q;
    logic [COL_W-1:0]     col_q;
    logic                 inflight;
    logic [ROW_W-1:0]     rd_row;
    logic [COL_W-1:0]     rd_col;
    logic                 rd_last;
    logic [CNT_W-1:0]     fifo_count;
    logic [ENT_W-1:0]     head;
    logic [OUT_WIDTH-1:0] conv_data;
    logic                 issue;
    logic                 last_addr;
    logic                 pop;
    logic                 flush_done;

    assign last_addr  = (row_q == ROW_W'(M - 1)) && (col_q == COL_W'(N - 1));
    assign issue      = (state == READ) &&
                        ((32'(fifo_count) + 32'(inflight)) < 32'(DRAIN_FIFO_DEPTH));
    assign pop        = out_if.out_valid && out_if.out_ready;
    // Count the pop happening now so DONE follows the last beat with no idle cycle
    assign flush_done = !inflight &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

`ifdef MAT_C_DRAIN_SAT_EN
    generate
        if (OUT_WIDTH < DW) begin : g_sat
            assign conv_data = (|data_in_c[DW-1:OUT_WIDTH]) ? '1 : data_in_c[OUT_WIDTH-1:0];
        end else begin : g_pass
            assign conv_data = data_in_c[OUT_WIDTH-1:0];
        end
    endgenerate
`else
    logic unused_hi_bits;
    assign conv_data      = data_in_c[OUT_WIDTH-1:0];
    assign unused_hi_bits = ^data_in_c;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; start outside IDLE is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (issue && last_addr) state_nxt = FLUSH;
            FLUSH:   if (flush_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: status and SRAM read port, addresses parked at zero when not reading
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        matrix_c_re = issue;
        row_addr_c  = issue ? row_q : '0;
        col_addr_c  = issue ? col_q : '0;
    end

    // Row-major read counters, column first, cleared when a drain starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else if ((state == IDLE) && start) begin
            row_q <= '0;
            col_q <= '0;
        end else if (issue) begin
            if (col_q == COL_W'(N - 1)) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Index of the read in flight, delayed one cycle to line up with SRAM data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            rd_row   <= '0;
            rd_col   <= '0;
            rd_last  <= 1'b0;
        end else begin
            inflight <= issue;
            rd_row   <= row_q;
            rd_col   <= col_q;
            rd_last  <= last_addr;
        end
    end

    mat_c_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DRAIN_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data ({conv_data, rd_row, rd_col, rd_last}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

    assign out_if.out_valid = (fifo_count != '0);
    assign {out_if.out_data, out_if.out_row, out_if.out_col, out_if.out_last} = head;

endmodule

// File: tb/tb_mat_c_drain.sv
// Bench for mat_c_drain: random SRAM contents and ready patterns against a row-major reference model.
// Latency: checks first beat at t+3 and done at t+3+M*N with ready held high.
// Backpressure: checks stall stability and that reads never exceed four outstanding elements.
module tb_mat_c_drain;

    localparam int M  = 2;
    localparam int N  = 3;
    localparam int MN = M * N;
    localparam int DW = 66;
    localparam int OW = 32;
    localparam int RW = $clog2(M);
    localparam int CW = $clog2(N);

    typedef struct {
        logic [OW-1:0] data;
        int            row;
        int            col;
        bit            last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          matrix_c_re;
    logic [RW-1:0] row_addr_c;
    logic [CW-1:0] col_addr_c;
    logic [DW-1:0] data_in_c = '0;

    logic [DW-1:0] sram [M][N];
    beat_t         exp_q [$];
    int            checks = 0;
    int            errors = 0;
    logic [OW-1:0] first_beat_data;

    mat_c_drain_if #(.OUT_WIDTH(OW), .ROW_W(RW), .COL_W(CW)) sif ();

    mat_c_drain #(
        .M                        (M),
        .N                        (N),
        .DATA_WIDTH_RESULT_MATRIX (DW),
        .OUT_WIDTH                (OW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .matrix_c_re (matrix_c_re),
        .row_addr_c  (row_addr_c),
        .col_addr_c  (col_addr_c),
        .data_in_c   (data_in_c),
        .out_if      (sif)
    );

    always #5 clk = ~clk;

    // SRAM C: one-cycle read latency; random junk on the bus when not reading
    always @(posedge clk) begin
        if (matrix_c_re) data_in_c <= sram[row_addr_c][col_addr_c];
        else             data_in_c <= DW'({$urandom(), $urandom(), $urandom()});
    end

    function automatic logic [OW-1:0] ref_conv(input logic [DW-1:0] v);
`ifdef MAT_C_DRAIN_SAT_EN
        if ((v >> OW) != 0) return {OW{1'b1}};
`endif
        return OW'(v % (DW'(1) << OW));
    endfunction

    function automatic bit ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k % 4) == 0) || ((k % 4) == 3);
            2:       return (k > 10);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill_sram();
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 2) == 0) sram[r][c] = DW'($urandom());
                else                           sram[r][c] = DW'({$urandom(), $urandom(), $urandom()});
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_re"},    matrix_c_re, 0);
        check({tag, "_addr"},  {row_addr_c, col_addr_c}, 0);
        check({tag, "_valid"}, sif.out_valid, 0);
        check({tag, "_data"},  sif.out_data, 0);
        check({tag, "_rc"},    {sif.out_row, sif.out_col}, 0);
        check({tag, "_last"},  sif.out_last, 0);
    endtask

    // One full drain: start pulse, per-cycle checks of reads, credit, beats and status
    task automatic run_drain(input int mode, input bit extra_start, input bit exact_timing);
        int    k, rd_idx, beats, done_k, last_hs_k, done_cnt, first_k;
        bit    prev_stall, finished;
        logic [OW+RW+CW:0] prev_out;
        beat_t e;
        exp_q.delete();
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                exp_q.push_back('{ref_conv(sram[r][c]), r, c, (r == M - 1) && (c == N - 1)});
            end
        end
        rd_idx = 0; beats = 0; done_k = -1; last_hs_k = -1; done_cnt = 0; first_k = -1;
        prev_stall = 0; finished = 0; prev_out = '0;
        @(negedge clk);
        start = 1'b1;
        sif.out_ready = ready_for(mode, 0);
        k = 0;
        check("busy_before_start", busy, 0);
        while (!finished && k < 200) begin
            @(negedge clk);
            k++;
            start = extra_start && (k == 2);
            sif.out_ready = ready_for(mode, k);
            if (matrix_c_re) begin
                check("no_extra_read", rd_idx < MN, 1);
                check("rd_row", row_addr_c, rd_idx / N);
                check("rd_col", col_addr_c, rd_idx % N);
                check("rd_credit", (rd_idx - beats) < 4, 1);
                rd_idx++;
            end else begin
                check("addr_idle", {row_addr_c, col_addr_c}, 0);
            end
            if (prev_stall) begin
                check("stall_hold", {sif.out_valid, sif.out_data, sif.out_row, sif.out_col, sif.out_last},
                      {1'b1, prev_out});
            end
            if (sif.out_valid && sif.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", sif.out_data, e.data);
                    check("beat_row",  sif.out_row, e.row);
                    check("beat_col",  sif.out_col, e.col);
                    check("beat_last", sif.out_last, e.last);
                end
                if (first_k < 0) begin
                    first_k = k;
                    first_beat_data = sif.out_data;
                end
                beats++;
                last_hs_k = k;
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_out   = {sif.out_data, sif.out_row, sif.out_col, sif.out_last};
            if (done) begin
                done_cnt++;
                done_k = k;
                check("done_after_last", k, last_hs_k + 1);
            end
            if (done_k >= 0 && k == done_k + 1) begin
                check("busy_fall", busy, 0);
                check("valid_idle_end", sif.out_valid, 0);
                finished = 1;
            end else begin
                check("busy_high", busy, 1);
            end
            if (mode == 2 && k == 10) check("stall_reads", rd_idx, 4);
        end
        start = 1'b0;
        check("drain_finished", finished, 1);
        check("beat_count", beats, MN);
        check("read_count", rd_idx, MN);
        check("done_count", done_cnt, 1);
        if (exact_timing) begin
            check("first_beat_time", first_k, 3);
            check("done_time", done_k, 3 + MN);
        end
    endtask

    initial begin
        sif.out_ready = 1'b1;
        #2 reset = 1'b1;
        #1 check_reset_vals("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("post_reset");

        // Wide element in (0,0): saturates or truncates depending on the build
        fill_sram();
        sram[0][0] = (DW'(1) << 40) + DW'(5);
        run_drain(0, 0, 1);
`ifdef MAT_C_DRAIN_SAT_EN
        check("wide_elem", first_beat_data, 32'hFFFF_FFFF);
`else
        check("wide_elem", first_beat_data, 32'h0000_0005);
`endif

        fill_sram();
        run_drain(1, 0, 0);

        fill_sram();
        run_drain(2, 0, 0);

        fill_sram();
        run_drain(3, 1, 0);

        // Reset in the middle of a drain: everything returns to idle with no done pulse
        fill_sram();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1 check_reset_vals("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sif.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_done_after_reset", done, 0);
            check("idle_after_reset", {busy, matrix_c_re, sif.out_valid}, 0);
        end

        fill_sram();
        run_drain(0, 0, 1);

        for (int i = 0; i < 3; i++) begin
            fill_sram();
            run_drain(3, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
